spike_rate_decoder: RTL
=======================

Name: spike_rate_decoder

Overview:
Downstream stage of the LIF neuron. It samples the neuron's spike output on every neuron integration step and accumulates per-window statistics: spike count and minimum inter-spike interval (ISI). At the close of each window it hands the result to a consumer through a single-entry valid/ready output buffer. A sticky overrun flag is raised if a result is lost.

Parameters:
WINDOW_BITS, 8, width of the window-length register and the step counter
COUNT_BITS, 8, width of the spike count; the count saturates at all-ones
ISI_BITS, 8, width of the ISI measurement; the ISI saturates at all-ones
DEFAULT_WINDOW, 16, window length loaded on reset

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = run windows; 0 = abort the window and go idle
step_valid  in  1  neuron produced a new membrane/spike this cycle
spike_in  in  1  neuron spike; sampled only when step_valid=1
cfg_load  in  1  latch window_len and restart the window
window_len  in  WINDOW_BITS  steps per window; 0 means 2^WINDOW_BITS
out_valid  out  1  result buffer holds an unconsumed result
out_ready  in  1  consumer accepts the result
out_count  out  COUNT_BITS  spikes in the window
out_isi_min  out  ISI_BITS  minimum ISI in steps; all-ones if fewer than 2 spikes
out_overrun  out  1  sticky flag: at least one window result was dropped
running  out  1  FSM is in RUN

Behaviour:
- Reset (asynchronous): FSM=IDLE, window length=DEFAULT_WINDOW, all counters 0, out_valid=0, out_count=0, out_isi_min=all-ones, out_overrun=0, running=0.
- FSM IDLE:
  - Go to RUN on the first clock edge with enable=1.
  - Step counter, spike count, gap counter and have_prev are cleared on entry.
- FSM RUN:
  - Return to IDLE on any edge with enable=0. The partial window is discarded; the output buffer is untouched.
- Step accounting: only in RUN, only on edges with step_valid=1.
  - step_cnt increments.
  - If spike_in=1: spike count increments (saturating).
    - If have_prev=1: candidate ISI = gap+1 (saturating); isi_min = min(isi_min, candidate).
    - Then gap<=0 and have_prev<=1.
  - If spike_in=0 and have_prev=1: gap increments (saturating).
- Window close: on the step edge where step_cnt reaches the window length. That step's spike is included.
  - The result goes to the buffer on the same edge, so out_valid is high the cycle after the closing step.
  - All window counters clear on that edge and isi_min is set to all-ones. The next window starts with no idle gap.
  - The ISI never spans two windows; have_prev is cleared at the close.
- Output handshake:
  - A transfer happens on an edge with out_valid=1 and out_ready=1.
  - out_valid stays high and the data stays stable until the transfer.
  - out_ready is ignored while out_valid=0.
- Simultaneous transfer and close: the new result loads, out_valid stays 1, no overrun.
- Close while out_valid=1 and out_ready=0: the new result is dropped, the buffer keeps the old result, and out_overrun is set.
- out_overrun clears on the next transfer edge, unless that same edge is also a dropped close.
- cfg_load=1 (any state):
  - window length <= window_len.
  - The current window is aborted and its counters cleared.
  - step_valid on the same edge is ignored.
  - The FSM state and output buffer are unaffected.
- Step counter compare: window_len=0 compares as 2^WINDOW_BITS. The counter is WINDOW_BITS+1 wide internally.
- Reset asserted mid-window or mid-handshake: immediate return to the reset values above. A pending result is lost.

Decomposition:
- Package spike_rate_pkg:
  - Width parameters and the DEFAULT_WINDOW constant.
  - FSM state enum {IDLE, RUN}.
  - A saturating-increment function used by the count, gap and ISI logic.
- One sub-module, spike_result_buffer: the single-entry valid/ready holding register with load/drop/overrun logic.
- The window FSM and accumulators stay in the top module.

Test Plan:
- Reset, enable=1, window_len=4 loaded, 4 steps with spikes at steps 1 and 3 -> out_valid one cycle after step 4, out_count=2, out_isi_min=2, out_overrun=0.
- Window of 4 with a single spike, then 4 steps with no spikes, out_ready=1 throughout -> results count=1 isi=255, then count=0 isi=255; back-to-back windows show no lost step.
- out_ready=0 across two window closes (counts 3 then 1), then out_ready=1 -> first accepted result is count=3 with out_overrun=1; overrun clears after the transfer.
- Window close on the same edge as a transfer -> new result loaded, out_valid stays 1, out_overrun stays 0.
- COUNT_BITS=8, window_len=0, spike on all 256 steps -> out_count=255 (saturated), out_isi_min=1.
- cfg_load mid-window after 2 spikes, and enable dropped mid-window -> the partial window is discarded and the next result counts only post-restart spikes. An asynchronous reset pulse while out_valid=1 -> out_valid=0 immediately.

Source files
------------

// File: rtl/spike_rate_pkg.sv
// rtl/spike_rate_pkg.sv - shared widths, window FSM states and saturating increment for the spike rate decoder
package spike_rate_pkg;

  localparam int WINDOW_BITS_DEF    = 8;
  localparam int COUNT_BITS_DEF     = 8;
  localparam int ISI_BITS_DEF       = 8;
  localparam int DEFAULT_WINDOW_DEF = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Widths up to 31 bits are carried in a 32-bit container; callers truncate back.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    sat_inc = (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/spike_result_buffer.sv
// rtl/spike_result_buffer.sv - single-entry valid/ready result register with drop and sticky overrun
module spike_result_buffer #(
  parameter int COUNT_BITS = 8,
  parameter int ISI_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [COUNT_BITS-1:0] count_i,
  input  logic [ISI_BITS-1:0]   isi_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [COUNT_BITS-1:0] count_o,
  output logic [ISI_BITS-1:0]   isi_o,
  output logic                  overrun_o
);

  logic                  valid_q, valid_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic [ISI_BITS-1:0]   isi_q, isi_d;
  logic                  overrun_q, overrun_d;
  logic                  xfer;
  logic                  drop;

  always_comb begin
    valid_d   = valid_q;
    count_d   = count_q;
    isi_d     = isi_q;
    overrun_d = overrun_q;
    xfer      = valid_q & ready_i;
    drop      = load_i & valid_q & ~ready_i;
    if (load_i && !drop) begin
      valid_d = 1'b1;
      count_d = count_i;
      isi_d   = isi_i;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    // A dropped close wins over a clearing transfer on the same edge.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (xfer) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      count_q   <= '0;
      isi_q     <= '1;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      count_q   <= count_d;
      isi_q     <= isi_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid_o   = valid_q;
  assign count_o   = count_q;
  assign isi_o     = isi_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - per-window spike count and minimum ISI of a LIF neuron spike train
module spike_rate_decoder
  import spike_rate_pkg::*;
#(
  parameter int WINDOW_BITS    = WINDOW_BITS_DEF,
  parameter int COUNT_BITS     = COUNT_BITS_DEF,
  parameter int ISI_BITS       = ISI_BITS_DEF,
  parameter int DEFAULT_WINDOW = DEFAULT_WINDOW_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   step_valid,
  input  logic                   spike_in,
  input  logic                   cfg_load,
  input  logic [WINDOW_BITS-1:0] window_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_BITS-1:0]  out_count,
  output logic [ISI_BITS-1:0]    out_isi_min,
  output logic                   out_overrun,
  output logic                   running
);

  localparam logic [31:0] CNT_MAX = 32'({COUNT_BITS{1'b1}});
  localparam logic [31:0] ISI_MAX = 32'({ISI_BITS{1'b1}});

  state_e                 state_q, state_d;
  logic [WINDOW_BITS-1:0] win_len_q, win_len_d;
  logic [WINDOW_BITS:0]   step_q, step_d;
  logic [COUNT_BITS-1:0]  count_q, count_d;
  logic [ISI_BITS-1:0]    gap_q, gap_d;
  logic [ISI_BITS-1:0]    isi_q, isi_d;
  logic                   have_prev_q, have_prev_d;

  logic [WINDOW_BITS:0]   target;
  logic [ISI_BITS-1:0]    cand;
  logic                   clr;
  logic                   close;

  always_comb begin
    state_d     = state_q;
    win_len_d   = win_len_q;
    step_d      = step_q;
    count_d     = count_q;
    gap_d       = gap_q;
    isi_d       = isi_q;
    have_prev_d = have_prev_q;
    clr         = 1'b0;
    close       = 1'b0;
    cand        = ISI_BITS'(sat_inc(32'(gap_q), ISI_MAX));
    // A zero length register means the full 2^WINDOW_BITS steps.
    target      = (win_len_q == '0) ? {1'b1, {WINDOW_BITS{1'b0}}} : {1'b0, win_len_q};

    if (cfg_load) begin
      win_len_d = window_len;
      clr       = 1'b1;
    end else if (state_q == ST_IDLE) begin
      clr = 1'b1;
      if (enable) state_d = ST_RUN;
    end else if (!enable) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
    end else if (step_valid) begin
      step_d = step_q + 1'b1;
      if (spike_in) begin
        count_d = COUNT_BITS'(sat_inc(32'(count_q), CNT_MAX));
        if (have_prev_q && (cand < isi_q)) isi_d = cand;
        gap_d       = '0;
        have_prev_d = 1'b1;
      end else if (have_prev_q) begin
        gap_d = ISI_BITS'(sat_inc(32'(gap_q), ISI_MAX));
      end
      if (step_d == target) begin
        close = 1'b1;
        clr   = 1'b1;
      end
    end

    if (clr) begin
      step_d      = '0;
      count_d     = '0;
      gap_d       = '0;
      isi_d       = '1;
      have_prev_d = 1'b0;
    end
  end

  logic [COUNT_BITS-1:0] res_count;
  logic [ISI_BITS-1:0]   res_isi;

  // The closing step's own spike is folded in before the counters clear.
  always_comb begin
    res_count = count_q;
    res_isi   = isi_q;
    if (spike_in) begin
      res_count = COUNT_BITS'(sat_inc(32'(count_q), CNT_MAX));
      if (have_prev_q && (cand < isi_q)) res_isi = cand;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      win_len_q   <= WINDOW_BITS'(DEFAULT_WINDOW);
      step_q      <= '0;
      count_q     <= '0;
      gap_q       <= '0;
      isi_q       <= '1;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_len_q   <= win_len_d;
      step_q      <= step_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      isi_q       <= isi_d;
      have_prev_q <= have_prev_d;
    end
  end

  spike_result_buffer #(
    .COUNT_BITS(COUNT_BITS),
    .ISI_BITS  (ISI_BITS)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .load_i   (close),
    .count_i  (res_count),
    .isi_i    (res_isi),
    .ready_i  (out_ready),
    .valid_o  (out_valid),
    .count_o  (out_count),
    .isi_o    (out_isi_min),
    .overrun_o(out_overrun)
  );

  assign running = (state_q == ST_RUN);

endmodule
